// File: rtl/barrido_lineas_pkg.sv
// Shared constants and FSM encoding for the line scan sequencer.
package barrido_lineas_pkg;

  localparam int unsigned SelW      = 3;
  localparam int unsigned NumLineas = 8;

  typedef enum logic {
    StInactivo = 1'b0,
    StBarrido  = 1'b1
  } estado_e;

endpackage

// File: rtl/divisor_barrido.sv
// Dwell prescaler: counts 0..Div-1 while enabled, pulses tick on the last count.
module divisor_barrido #(
  parameter int unsigned Div = 1000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(Div);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Terminal count only counts as a tick while the scan is running.
  assign tick_o = en_i && (cnt_q == CntW'(Div - 1));

  // Next prescaler value: clear dominates, wrap on tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
    end
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/barrido_lineas.sv
// Scan sequencer for a 3-to-8 line decoder: steps the select, debounces each line's
// return sample across sweeps and reports presses through a valid/accept handshake.
module barrido_lineas
  import barrido_lineas_pkg::*;
#(
  parameter int unsigned DIV = 1000,
  parameter int unsigned DEB = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            habilitar,
  output logic [SelW-1:0] sel,
  input  logic            retorno,
  output logic [SelW-1:0] codigo,
  output logic            valido,
  input  logic            aceptado,
  output logic            desborde
);

  localparam int unsigned CntW = $clog2(DEB + 1);

  estado_e              estado_q, estado_d;
  logic [SelW-1:0]      sel_q, sel_d;
  logic [NumLineas-1:0] level_q, level_d;
  logic [CntW-1:0]      cnt_q [NumLineas];
  logic [CntW-1:0]      cnt_d [NumLineas];
  logic [CntW-1:0]      cnt_inc;
  logic                 ev_q, ev_d;
  logic [SelW-1:0]      ev_code_q, ev_code_d;
  logic [SelW-1:0]      codigo_q, codigo_d;
  logic                 valido_q, valido_d;
  logic                 desborde_q, desborde_d;
  logic                 activo;
  logic                 tick;

  // Falling habilitar drops out of the scan in the same cycle, so no sample is taken.
  assign activo = (estado_q == StBarrido) && habilitar;

  divisor_barrido #(
    .Div (DIV)
  ) u_divisor (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (!activo),
    .en_i    (activo),
    .tick_o  (tick)
  );

  // FSM next state.
  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      StInactivo: if (habilitar)  estado_d = StBarrido;
      StBarrido:  if (!habilitar) estado_d = StInactivo;
      default:    estado_d = StInactivo;
    endcase
  end

  // Select stepping and per-line debounce of the sampled line.
  always_comb begin
    sel_d     = sel_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    ev_d      = 1'b0;
    ev_code_d = ev_code_q;
    cnt_inc   = cnt_q[sel_q] + CntW'(1);
    if (!activo) begin
      sel_d = '0;
      for (int i = 0; i < NumLineas; i++) cnt_d[i] = '0;
    end else if (tick) begin
      sel_d     = sel_q + SelW'(1);
      ev_code_d = ~sel_q;
      if (retorno == level_q[sel_q]) begin
        cnt_d[sel_q] = '0;
      end else if (cnt_inc == CntW'(DEB)) begin
        level_d[sel_q] = retorno;
        cnt_d[sel_q]   = '0;
        ev_d           = retorno;  // only 0->1 is reported
      end else begin
        cnt_d[sel_q] = cnt_inc;
      end
    end
  end

  // Output register: a new event wins over an accept; a full register drops it.
  always_comb begin
    codigo_d   = codigo_q;
    valido_d   = valido_q;
    desborde_d = desborde_q;
    if (ev_q) begin
      if (valido_q && !aceptado) begin
        desborde_d = 1'b1;
      end else begin
        codigo_d = ev_code_q;
        valido_d = 1'b1;
      end
    end else if (valido_q && aceptado) begin
      valido_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= StInactivo;
      sel_q      <= '0;
      level_q    <= '0;
      ev_q       <= 1'b0;
      ev_code_q  <= '0;
      codigo_q   <= '0;
      valido_q   <= 1'b0;
      desborde_q <= 1'b0;
      for (int i = 0; i < NumLineas; i++) cnt_q[i] <= '0;
    end else begin
      estado_q   <= estado_d;
      sel_q      <= sel_d;
      level_q    <= level_d;
      ev_q       <= ev_d;
      ev_code_q  <= ev_code_d;
      codigo_q   <= codigo_d;
      valido_q   <= valido_d;
      desborde_q <= desborde_d;
      for (int i = 0; i < NumLineas; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sel      = sel_q;
  assign codigo   = codigo_q;
  assign valido   = valido_q;
  assign desborde = desborde_q;

endmodule

// File: tb/tb_barrido_lineas.sv
// Randomized bench for barrido_lineas with a time-based reference model and a
// scoreboard queue of expected reported line codes.
module tb_barrido_lineas;

  localparam int unsigned DIV    = 4;
  localparam int unsigned DEB    = 2;
  localparam int unsigned NCYC   = 8000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       habilitar = 1'b0;
  logic       retorno = 1'b0;
  logic       aceptado = 1'b0;
  logic [2:0] sel;
  logic [2:0] codigo;
  logic       valido;
  logic       desborde;

  int vectors = 0;
  int errors  = 0;
  bit done    = 1'b0;

  barrido_lineas #(
    .DIV (DIV),
    .DEB (DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .habilitar (habilitar),
    .sel       (sel),
    .retorno   (retorno),
    .codigo    (codigo),
    .valido    (valido),
    .aceptado  (aceptado),
    .desborde  (desborde)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Scan position is derived from the number of cycles spent scanning.
  bit       m_scan;
  int       m_k;
  int       m_sel;
  bit       m_level [8];
  int       m_cnt [8];
  bit       m_ev;
  int       m_ev_code;
  bit       m_valid;
  int       m_codigo;
  bit       m_desb;
  int       exp_q [$];

  always @(posedge clk) begin
    bit ev_next;
    int code_next;
    ev_next   = 1'b0;
    code_next = 0;
    if (reset) begin
      m_scan = 0; m_k = 0; m_sel = 0; m_ev = 0; m_ev_code = 0;
      m_valid = 0; m_codigo = 0; m_desb = 0;
      for (int i = 0; i < 8; i++) begin m_level[i] = 0; m_cnt[i] = 0; end
      exp_q.delete();
    end else begin
      if (m_ev) begin
        if (m_valid && !aceptado) m_desb = 1;
        else begin
          m_codigo = m_ev_code;
          m_valid  = 1;
          exp_q.push_back(m_ev_code);
        end
      end else if (m_valid && aceptado) begin
        m_valid = 0;
      end
      if (m_scan && habilitar) begin
        int s;
        s = (m_k / DIV) % 8;
        if (m_k % DIV == DIV - 1) begin
          if (retorno == m_level[s]) m_cnt[s] = 0;
          else begin
            m_cnt[s]++;
            if (m_cnt[s] >= DEB) begin
              m_level[s] = retorno;
              m_cnt[s]   = 0;
              if (retorno) begin ev_next = 1; code_next = 7 - s; end
            end
          end
        end
        m_k++;
        m_sel = (m_k / DIV) % 8;
      end else begin
        m_k   = 0;
        m_sel = 0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      end
      m_scan    = habilitar;
      m_ev      = ev_next;
      m_ev_code = code_next;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit prev_v   = 1'b0;
  bit prev_acc = 1'b0;

  always @(negedge clk) begin
    if (!done) begin
      check("sel", int'(sel), m_sel);
      check("valido", int'(valido), int'(m_valid));
      check("desborde", int'(desborde), int'(m_desb));
      if (valido && (!prev_v || prev_acc)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", int'(codigo), -1);
        end else begin
          check("codigo", int'(codigo), exp_q.pop_front());
        end
      end else if (valido) begin
        check("codigo_held", int'(codigo), m_codigo);
      end
      prev_v   = valido;
      prev_acc = aceptado;
    end
  end

  // ---------------- stimulus ----------------
  bit pressed [8];

  initial begin
    for (int i = 0; i < 8; i++) pressed[i] = 0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #2;
      reset = (c == NCYC / 2) || (c == NCYC / 2 + 1);
      if ($urandom_range(0, 299) == 0) habilitar = 1'b0;
      else if (!habilitar && $urandom_range(0, 19) == 0) habilitar = 1'b1;
      else if (c == 5) habilitar = 1'b1;
      if ($urandom_range(0, 39) == 0) begin
        int l;
        l = $urandom_range(0, 7);
        pressed[l] = !pressed[l];
      end
      // Occasional glitches exercise a single differing sample.
      retorno  = pressed[m_sel] ^ ($urandom_range(0, 29) == 0);
      aceptado = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    done = 1'b1;
    check("leftover_events", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
